// File: rtl/led_player_pkg.sv
// Shared types and constants for the LED pattern player: FSM state encoding and
// the layout of a pattern-table entry word.
package led_player_pkg;

    localparam int LED_W   = 18;
    localparam int DUR_W   = 14;
    localparam int DUR_LSB = 18;
    localparam int ADDR_W  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // A stored duration of zero still shows the pattern for one tick.
    function automatic logic [DUR_W-1:0] hold_min1(input logic [DUR_W-1:0] dur);
        return (dur == '0) ? DUR_W'(1) : dur;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Hold-tick prescaler: counts 0..TICK_DIV-1 and emits a one-cycle tick on each wrap.
// Synchronous clear holds the count at zero.
module led_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/led_pattern_player.sv
// Avalon-MM read master that plays a table of {hold, pattern} words from pattern RAM onto the LEDs.
// Optional LED_PLAYER_LOOP_EN adds a loop input that replays the table from base_addr.
//
// state | meaning
// IDLE  | waiting for start; led keeps last pattern
// FETCH | RAM read issued for base+index
// WAIT  | read data returns; led and hold loaded
// HOLD  | pattern shown for hold ticks of TICK_DIV cycles
module led_pattern_player #(
    parameter int TICK_DIV = 50000,
    parameter int ADDR_W   = 10,
    parameter int LED_W    = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_entries,
`ifdef LED_PLAYER_LOOP_EN
    input  logic              loop,
`endif
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_clken,
    output logic              ram_write,
    output logic [3:0]        ram_byteenable,
    input  logic [31:0]       ram_readdata,
    output logic [LED_W-1:0]  led,
    output logic              busy,
    output logic              done
);
    import led_player_pkg::*;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, addr_q;
    logic [ADDR_W:0]   count_q, index_q, index_nx;
    logic [DUR_W-1:0]  hold_q;
    logic              tick, accept, last_tick, more, loop_act;

`ifdef LED_PLAYER_LOOP_EN
    assign loop_act = loop;
`else
    assign loop_act = 1'b0;
`endif

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (state_q != HOLD),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        accept    = (state_q == IDLE) && start && !stop;
        index_nx  = index_q + (ADDR_W + 1)'(1);
        more      = index_nx < count_q;
        last_tick = (state_q == HOLD) && tick && (hold_q == DUR_W'(1));
        unique case (state_q)
            IDLE:    if (accept && num_entries != '0) state_d = FETCH;
            FETCH:   state_d = WAIT;
            WAIT:    state_d = HOLD;
            HOLD:    if (last_tick) state_d = (more || loop_act) ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
        if (stop && state_q != IDLE) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            count_q <= '0;
            index_q <= '0;
            hold_q  <= '0;
            led     <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            if (stop && state_q != IDLE) begin
                led <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (accept) begin
                            if (num_entries != '0) begin
                                base_q  <= base_addr;
                                count_q <= num_entries;
                                index_q <= '0;
                                addr_q  <= base_addr;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    WAIT: begin
                        led    <= ram_readdata[LED_W-1:0];
                        hold_q <= hold_min1(ram_readdata[DUR_LSB +: DUR_W]);
                    end
                    HOLD: begin
                        if (tick) hold_q <= hold_q - DUR_W'(1);
                        if (last_tick) begin
                            // Address is precomputed here so FETCH drives it straight from a flop.
                            if (more) begin
                                index_q <= index_nx;
                                addr_q  <= base_q + index_nx[ADDR_W-1:0];
                            end else if (loop_act) begin
                                index_q <= '0;
                                addr_q  <= base_q;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy           = (state_q != IDLE);
    assign ram_chipselect = (state_q == FETCH);
    assign ram_address    = addr_q;
    assign ram_clken      = 1'b1;
    assign ram_write      = 1'b0;
    assign ram_byteenable = 4'hF;

endmodule
